locking_rr_arbiter: RTL
=======================

LOCKING_RR_ARBITER -- requirements
Module: locking_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; legal range 2..32, not restricted to powers of two.
REQ-002 Parameter MAX_HOLD, default 16, maximum beats per grant; used only when LRA_TIMEOUT_EN is defined.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  N_REQ  per-requester request; bit i high = requester i has a beat pending.
REQ-006 last  input  N_REQ  per-requester end-of-burst flag, qualified by req.
REQ-007 res_ready  input  1  shared resource accepts a beat this cycle.
REQ-008 grant  output  N_REQ  one-hot or zero, registered; current owner.
REQ-009 grant_id  output  $clog2(N_REQ)  binary index of owner, registered; 0 when idle.
REQ-010 busy  output  1  registered; high while a grant is held.
REQ-011 beat  output  1  combinational: busy & res_ready & req[grant_id].
REQ-012 timeout  output  1  registered one-cycle pulse on forced release; tied 0 without LRA_TIMEOUT_EN.

Function
REQ-013 FSM states: IDLE (no owner) and HOLD (one owner); busy SHALL be high exactly in HOLD.
REQ-014 Arbitration SHALL pick the first set req bit scanning upward from ptr, wrapping N_REQ-1 -> 0.
REQ-015 IDLE with any req set -> HOLD next cycle; grant/grant_id show the winner from that edge (1-cycle latency).
REQ-016 IDLE with req == 0 SHALL stay IDLE; grant == 0.
REQ-017 In HOLD, grant SHALL stay constant until the release beat, regardless of other requests.
REQ-018 Owner deasserting req in HOLD SHALL keep the grant; no beat is counted.
REQ-019 Release beat = beat & last[grant_id]; on it, ptr <= (grant_id+1) mod N_REQ.
REQ-020 On a release beat, re-arbitration SHALL happen in the same cycle using the new ptr and current req excluding the releasing owner; a winner is granted next cycle with no idle bubble, else -> IDLE.
REQ-021 Releasing owner is excluded only in that cycle; it may win in IDLE next cycle if alone.
REQ-022 ptr SHALL NOT change on a grant, only on release.
REQ-023 res_ready with busy low SHALL have no effect.

Reset
REQ-024 On rst: state IDLE, ptr 0, grant 0, grant_id 0, busy 0, timeout 0, beat counter 0.
REQ-025 rst asserted mid-burst SHALL drop the grant immediately (asynchronously); no release or ptr update is recorded.

Configuration
REQ-026 With LRA_TIMEOUT_EN defined: a beat counter SHALL clear on every grant and increment per beat; the MAX_HOLD-th beat without last SHALL be a forced release per REQ-019/020, and timeout SHALL pulse the next cycle.
REQ-027 A beat that both has last set and reaches MAX_HOLD SHALL be a normal release; timeout stays 0.
REQ-028 Without LRA_TIMEOUT_EN: no counter, no forced release, timeout constant 0, MAX_HOLD ignored.

Structure
REQ-029 Package lra_pkg SHALL hold the state enum (LRA_IDLE, LRA_HOLD) and the width function for grant_id/ptr.
REQ-030 Sub-module rr_pick (combinational: req, ptr, mask -> one-hot, index, any) SHALL implement REQ-014/020; the top holds FSM, ptr, counter and output registers.

Verification (N_REQ=4, MAX_HOLD=4 unless noted)
REQ-031 After reset, req=4'b1010, res_ready=1, last=4'b1010 -> cycle 1 grant=0010, beat; cycle 2 grant=1000 (no bubble); cycle 3 grant=0010.
REQ-032 Owner 0 bursts 3 beats (last on beat 3) while req=4'b1111 -> grant=0001 constant for 3 beats, then 0010; ptr=1.
REQ-033 Owner 3 releases with req=4'b1001 -> wrap: next grant=0001; owner 3 requests alone afterwards -> IDLE one cycle, then grant=1000.
REQ-034 res_ready=0 for 5 cycles mid-burst -> grant held, beat=0, counter frozen; resumes on res_ready=1.
REQ-035 LRA_TIMEOUT_EN, owner 2 never asserts last, res_ready=1 -> release after 4th beat, timeout=1 one cycle, grant moves to requester 3 if requesting; without macro grant held indefinitely.
REQ-036 rst pulsed during beat 2 of a burst -> grant=0 immediately; after rst low, req=4'b0100 -> grant=0100 via ptr=0 scan.

Source files
------------

// File: rtl/lra_pkg.sv
// Shared types and sizing helper for the locking round-robin arbiter.
package lra_pkg;

  typedef enum logic {
    LRA_IDLE = 1'b0,
    LRA_HOLD = 1'b1
  } lra_state_e;

  // Index width for grant_id / ptr / beat counter; never narrower than 1 bit.
  function automatic int lra_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first unmasked request at or above ptr, wrapping.
module rr_pick
  import lra_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]              req,
  input  logic [lra_idx_w(N_REQ)-1:0]   ptr,
  input  logic [N_REQ-1:0]              mask,
  output logic [N_REQ-1:0]              onehot,
  output logic [lra_idx_w(N_REQ)-1:0]   idx,
  output logic                          any_req
);

  localparam int IW = lra_idx_w(N_REQ);

  logic [N_REQ-1:0] eff;
  logic [IW-1:0]    pos;

  assign eff = req & ~mask;

  // Modulo wrap keeps non-power-of-two N_REQ from scanning phantom slots.
  always_comb begin
    onehot  = '0;
    idx     = '0;
    any_req = 1'b0;
    pos     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      pos = IW'((int'(ptr) + off) % N_REQ);
      if (!any_req && eff[pos]) begin
        any_req     = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/locking_rr_arbiter.sv
// Round-robin arbiter that locks a grant until the owner's last beat.
// Optional forced release after MAX_HOLD beats when LRA_TIMEOUT_EN is defined.
//
// state    | meaning
// LRA_IDLE | no owner, arbitrate every cycle
// LRA_HOLD | one owner, grant frozen until release beat
module locking_rr_arbiter
  import lra_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              last,
  input  logic                          res_ready,
  output logic [N_REQ-1:0]              grant,
  output logic [lra_idx_w(N_REQ)-1:0]   grant_id,
  output logic                          busy,
  output logic                          beat,
  output logic                          timeout
);

  localparam int IW = lra_idx_w(N_REQ);

  lra_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, id_d, rel_ptr, pick_ptr, pick_idx;
  logic [N_REQ-1:0] grant_d, pick_mask, pick_oh;
  logic             pick_any, last_own, rel, forced;

  assign busy     = (state_q == LRA_HOLD);
  assign beat     = busy & res_ready & req[grant_id];
  assign last_own = last[grant_id];
  assign rel      = beat & (last_own | forced);
  assign rel_ptr  = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);

  // While holding, the picker already looks at the post-release pointer
  // and masks the current owner, so a release hands over with no bubble.
  assign pick_ptr  = busy ? rel_ptr : ptr_q;
  assign pick_mask = busy ? grant : '0;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .mask    (pick_mask),
    .onehot  (pick_oh),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant;
    id_d    = grant_id;
    unique case (state_q)
      LRA_IDLE: begin
        if (pick_any) begin
          state_d = LRA_HOLD;
          grant_d = pick_oh;
          id_d    = pick_idx;
        end
      end
      LRA_HOLD: begin
        if (rel) begin
          ptr_d = rel_ptr;
          if (pick_any) begin
            grant_d = pick_oh;
            id_d    = pick_idx;
          end else begin
            state_d = LRA_IDLE;
            grant_d = '0;
            id_d    = '0;
          end
        end
      end
      default: begin
        state_d = LRA_IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LRA_IDLE;
      ptr_q    <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant    <= grant_d;
      grant_id <= id_d;
    end
  end

`ifdef LRA_TIMEOUT_EN
  localparam int CW = lra_idx_w(MAX_HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  // Counter holds beats already taken; the MAX_HOLD-th beat sees MAX_HOLD-1.
  assign forced  = beat & ~last_own & (cnt_q == CW'(MAX_HOLD - 1));
  assign timeout = timeout_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      if (pick_any) cnt_d = '0;
    end else if (rel) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= forced;
    end
  end
`else
  logic unused_max_hold;

  assign forced          = 1'b0;
  assign timeout         = 1'b0;
  assign unused_max_hold = (MAX_HOLD > 0);
`endif

endmodule
